// File: rtl/sr_latch_driver.sv
// Write controller for an external SR latch: pulses s or r, then settles, verifies and retries.
// Define SR_LATCH_DRIVER_STATS_EN to enable the saturating pulse_cnt counter.
module sr_latch_driver #(
    parameter int PULSE_W   = 2,
    parameter int SETTLE_W  = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_value,
    input  logic        q_fb,
    output logic        s,
    output logic        r,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] pulse_cnt
);

    localparam int TW = $clog2(256);
    localparam int RW = $clog2(16);

    localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] SETTLE_LAST =
        TW'((SETTLE_W > 0) ? SETTLE_W - 1 : 0);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          value_q, value_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        value_d = value_q;
        s_d     = s_q;
        r_d     = r_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (q_fb == req_value) begin
                        ack_d = 1'b1;
                    end else begin
                        value_d = req_value;
                        state_d = PULSE;
                        busy_d  = 1'b1;
                        s_d     = req_value;
                        r_d     = ~req_value;
                        timer_d = '0;
                        retry_d = '0;
                    end
                end
            end
            PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    timer_d = '0;
                    state_d = (SETTLE_W > 0) ? SETTLE : CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = CHECK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if (q_fb == value_q) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (retry_q < RETRY_MAX) begin
                    // Same polarity as the original request, regardless of req_value now.
                    retry_d = retry_q + 1'b1;
                    state_d = PULSE;
                    s_d     = value_q;
                    r_d     = ~value_q;
                    timer_d = '0;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            value_q <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            value_q <= value_d;
            s_q     <= s_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign s    = s_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign ack  = ack_q;
    assign err  = err_q;

`ifdef SR_LATCH_DRIVER_STATS_EN
    logic        pulse_inc;
    logic [15:0] pulse_cnt_q, pulse_cnt_d;

    // Every PULSE entry comes from IDLE or CHECK, so count transitions into it.
    assign pulse_inc = (state_q != PULSE) && (state_d == PULSE);

    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (pulse_inc && (pulse_cnt_q != 16'hFFFF)) begin
            pulse_cnt_d = pulse_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt_q <= 16'h0000;
        end else begin
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign pulse_cnt = pulse_cnt_q;
`else
    assign pulse_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural latch model on q_fb.
// Vector table plus hand sequences for reset, retry recovery, busy drop and randomised invariants.
module tb_sr_latch_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_value;
    logic        q_fb;
    logic        s;
    logic        r;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] pulse_cnt;

    sr_latch_driver dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_value (req_value),
        .q_fb      (q_fb),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    logic lat_q = 1'b0;
    logic preset_en = 1'b0;
    logic preset_val = 1'b0;
    logic stuck = 1'b0;
    logic stuck_val = 1'b0;

    always @(posedge clk) begin
        if (s) lat_q <= 1'b1;
        else if (r) lat_q <= 1'b0;
        else if (preset_en) lat_q <= preset_val;
    end

    assign q_fb = stuck ? stuck_val : lat_q;

    int total = 0;
    int bad = 0;
    int exp_pc = 0;
    int sr_viol = 0;

    always @(s, r) begin
        if (s && r) sr_viol++;
    end

    assert property (@(posedge clk) !(s && r))
        else $error("s and r high together");

    typedef struct {
        logic pq;
        logic val;
        logic stk;
        logic sv;
        int   lat;
        logic e;
        int   np;
    } vec_t;

    typedef struct {
        logic val;
        int   lat;
        logic e;
        int   np;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pc_exp();
`ifdef SR_LATCH_DRIVER_STATS_EN
        return exp_pc;
`else
        return 0;
`endif
    endfunction

    task automatic setup(input logic pq, input logic stk, input logic sv);
        stuck      = stk;
        stuck_val  = sv;
        preset_en  = 1'b1;
        preset_val = pq;
        step();
        preset_en  = 1'b0;
        step();
    endtask

    task automatic issue(input logic val, input int lat, input logic e,
                         input int np);
        exp_t ex;
        ex.val = val;
        ex.lat = lat;
        ex.e   = e;
        ex.np  = np;
        sb.push_back(ex);
        req_valid = 1'b1;
        req_value = val;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int rel, input int inj);
        exp_t ex;
        int   t, sp, rp, sh, rh;
        logic ps, pr, b0, cur;
        t = 0; sp = 0; rp = 0; sh = 0; rh = 0;
        ps = 1'b0; pr = 1'b0;
        b0 = busy;
        cur = req_value;
        while (!ack && t < 40) begin
            if (s) sh++;
            if (r) rh++;
            if (s && !ps) sp++;
            if (r && !pr) rp++;
            ps = s;
            pr = r;
            if (t == rel) stuck = 1'b0;
            if (t == inj) begin
                req_valid = 1'b1;
                req_value = ~cur;
            end else if (t == inj + 1) begin
                req_valid = 1'b0;
            end
            step();
            t++;
        end
        req_valid = 1'b0;
        check({tag, "_ack_seen"}, int'(ack), 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            ex = sb.pop_front();
            exp_pc += ex.np;
            check({tag, "_latency"}, t, ex.lat);
            check({tag, "_err"}, int'(err), int'(ex.e));
            check({tag, "_pulses"}, ex.val ? sp : rp, ex.np);
            check({tag, "_wrong_pol"}, ex.val ? rp : sp, 0);
            check({tag, "_hi_cycles"}, ex.val ? sh : rh, ex.np * 2);
            check({tag, "_busy"}, int'(b0), (ex.np > 0) ? 1 : 0);
            check({tag, "_pulse_cnt"}, int'(pulse_cnt), pc_exp());
        end
    endtask

    vec_t vecs[6];

    initial begin
        int   viol_ack;
        logic prev_ack, pre_busy, pre_req;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 12, 1'b1, 3};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 12, 1'b1, 3};

        rst = 1'b1;
        req_valid = 1'b0;
        req_value = 1'b0;
        #12;
        check("rst_s", int'(s), 0);
        check("rst_r", int'(r), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_err", int'(err), 0);
        check("rst_pulse_cnt", int'(pulse_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        setup(1'b0, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_value = 1'b1;
        step();
        req_valid = 1'b0;
        check("midpulse_s", int'(s), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_s", int'(s), 0);
        check("async_rst_r", int'(r), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ack", int'(ack), 0);
        check("async_rst_err", int'(err), 0);
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_s", int'(s), 0);
        check("post_rst_pulse_cnt", int'(pulse_cnt), 0);
        exp_pc = 0;

        for (int i = 0; i < 6; i++) begin
            setup(vecs[i].pq, vecs[i].stk, vecs[i].sv);
            issue(vecs[i].val, vecs[i].lat, vecs[i].e, vecs[i].np);
            wait_ack($sformatf("vec%0d", i), -1, -1);
            step();
            check($sformatf("vec%0d_ack_once", i), int'(ack), 0);
        end

        setup(1'b0, 1'b1, 1'b0);
        issue(1'b1, 8, 1'b0, 2);
        wait_ack("recover", 5, -1);
        step();

        setup(1'b1, 1'b0, 1'b0);
        issue(1'b0, 4, 1'b0, 1);
        wait_ack("drop", -1, 2);
        issue(1'b1, 4, 1'b0, 1);
        check("b2b_s", int'(s), 1);
        check("b2b_busy", int'(busy), 1);
        check("b2b_ack_low", int'(ack), 0);
        wait_ack("b2b", -1, -1);
        step();

        stuck = 1'b1;
        viol_ack = 0;
        prev_ack = ack;
        for (int k = 0; k < 10000; k++) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_value = 1'($urandom_range(0, 1));
            stuck_val = 1'($urandom_range(0, 1));
            pre_busy = busy;
            pre_req = req_valid;
            step();
            if (ack && prev_ack && !(pre_req && !pre_busy)) viol_ack++;
            prev_ack = ack;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 60 && busy; k++) step();
        check("rand_idle", int'(busy), 0);
        check("rand_ack_run", viol_ack, 0);
        check("sr_overlap", sr_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Clocked write-side controller for an external SR latch cell. It accepts a one-bit write request with a valid/busy handshake and produces clean, mutually exclusive set/reset pulses of programmable width. It then waits a settle interval, checks the latch output fed back on q_fb, and retries on mismatch. It sits between synchronous control logic and any level-sensitive SR storage element, and guarantees s=r=1 is never driven.

Parameters:
PULSE_W, 2, cycles s or r is held high per attempt (legal range 1..255)
SETTLE_W, 1, idle cycles with s=r=0 after the pulse, before the check (legal range 0..255)
MAX_RETRY, 2, extra pulse attempts after the first fails verification (legal range 0..15)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  write request; accepted on a rising edge when req_valid=1 and busy=0
req_value  input  1  value to store: 1 drives set, 0 drives reset
q_fb  input  1  latch q output, fed back (sampled only in IDLE acceptance and CHECK)
s  output  1  set drive to the latch
r  output  1  reset drive to the latch
busy  output  1  high while a write is in progress; requests are ignored while high
ack  output  1  one-cycle pulse: write completed (success or failure)
err  output  1  one-cycle pulse, coincident with ack: all attempts failed verification
pulse_cnt  output  16  total pulses issued (see Optional Feature)

Behaviour:
- All outputs are registered. rst asserted forces s=0, r=0, busy=0, ack=0, err=0, pulse_cnt=0, state=IDLE, retry count=0 immediately, regardless of clk. This also applies mid-pulse, so a pulse may be truncated.
- FSM states: IDLE, PULSE, SETTLE, CHECK.
- IDLE: ack and err default to 0 each cycle. On an edge with req_valid=1:
  - If q_fb==req_value: no pulse is issued. ack<=1 and state stays IDLE (skip write).
  - Otherwise: latch req_value internally, state<=PULSE, busy<=1, s<=req_value, r<=~req_value, pulse timer=0, retry=0.
- PULSE: the active drive is held for exactly PULSE_W cycles. On the last cycle, s<=0 and r<=0. The next state is SETTLE if SETTLE_W>0, else CHECK.
- SETTLE: s=r=0 for exactly SETTLE_W cycles, then CHECK.
- CHECK: lasts one cycle, with q_fb sampled at its closing edge.
  - Match: ack<=1, busy<=0, state<=IDLE.
  - Mismatch with retry<MAX_RETRY: retry<=retry+1, re-enter PULSE with the same value.
  - Mismatch with retry==MAX_RETRY: ack<=1, err<=1, busy<=0, state<=IDLE.
- Latency: request accepted at edge E0. s/r are high from E0 to E0+PULSE_W. On success, ack rises at edge E0+PULSE_W+SETTLE_W+1. With defaults, ack rises at E0+4 and busy is high for 4 cycles. Each retry adds PULSE_W+SETTLE_W+1 cycles.
- Back-to-back requests: a request may be accepted on the same edge at which ack is high (busy=0 in that cycle). Requests with busy=1 are dropped, not queued.
- Invariant: s&&r is never 1 in any cycle, including during reset assertion or deassertion.
- req_value and q_fb changes during busy do not affect the pulse polarity. q_fb is ignored outside the acceptance and CHECK edges.
- Internal counters are sized by $clog2 of their parameter maximums; there is no wrap inside legal ranges.

Optional Feature:
Macro SR_LATCH_DRIVER_STATS_EN.
- Defined: pulse_cnt increments by 1 on every entry into PULSE, including retries. It saturates at 16'hFFFF and is cleared only by rst.
- Undefined: pulse_cnt is tied to 16'h0000 and no counter logic is synthesised. The port list is unchanged.

Test Plan:
- Reset: assert rst mid-PULSE with s=1 -> s, r, busy, ack, err all 0 within the same cycle. After release, state IDLE and pulse_cnt=0.
- Normal set (defaults): q_fb=0; req_valid=1, req_value=1 at E0 -> s=1 for 2 cycles, then 1 cycle s=r=0, q_fb driven to 1 -> ack=1, err=0 at E0+4, busy high E0..E0+4.
- Skip write: q_fb=1; req_value=1 accepted -> ack=1 on the next cycle, s and r stay 0, busy stays 0, pulse_cnt unchanged.
- Retry then fail (MAX_RETRY=2): q_fb held 0, req_value=1 -> three s pulses of 2 cycles each, then ack=1 and err=1 at E0+12. pulse_cnt=3 with the macro defined, 0 without.
- Busy drop and back-to-back: reset write accepted; second request asserted during busy is ignored (r pulses only once). A new request asserted in the ack cycle is accepted and starts its pulse on the following cycle.
- Invariant check: randomised req/q_fb for 10k cycles -> assertion that s&&r is never 1, and that ack is never high for more than one consecutive cycle without an accepted request.
